pc_fetch_ctrl: RTL and testbench
================================

# pc_fetch_ctrl

Fetch-side consumer of the decode-stage branch decision. Holds the fetch PC, issues instruction requests on the SRAM-like instruction port toward the AXI bridge, and applies taken-branch, jump, register-jump and exception redirects with MIPS delay-slot semantics. Sits between the decode-stage branch comparator (which supplies `EqualD` and the forwarded `realRD1`) and the instruction-side bridge, and feeds F→D.

## Interface
- `RESET_PC`, 32'hBFC0_0000, PC after reset
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high; shared with the instruction bridge
- `StallF`  in  1  F→D advance blocked this cycle
- `BranchTakenD`  in  1  decode-stage control transfer resolved taken this cycle (`EqualD` qualified by decode fire); one-cycle pulse per instruction
- `PCSrcD`  in  2  00 branch offset, 01 J-type, 10 register, 11 reserved (treated as 00)
- `PCPlus4D`  in  32  PC+4 of the decode-stage instruction
- `ImmD`  in  16  branch offset
- `InstrIndexD`  in  26  J-type index
- `RegTargetD`  in  32  forwarded register target
- `ExcRedirect`  in  1  exception/ERET redirect pulse, highest priority
- `ExcPC`  in  32  redirect address for `ExcRedirect`
- `inst_req`  out  1  request valid
- `inst_addr`  out  32  request address (= `PCF`)
- `inst_addr_ok`  in  1  request accepted
- `inst_data_ok`  in  1  read data valid
- `inst_rdata`  in  32  read data
- `PCF`  out  32  fetch PC
- `InstrF`  out  32  fetched instruction
- `InstValidF`  out  1  `InstrF` valid for F→D
- `AdELF`  out  1  `InstrF` slot is a misaligned-fetch fault

## Operation
- Target: 00/11 → `PCPlus4D + {{14{ImmD[15]}},ImmD,2'b00}` (32-bit wrap); 01 → `{PCPlus4D[31:28],InstrIndexD,2'b00}`; 10 → `RegTargetD`.
- `next_pc` priority: `BranchTakenD` ? live target : `redir_valid` ? `redir_target` : `PCF+4` (wraps at 2^32).
- Advance = `InstValidF && !StallF`: `PCF <= next_pc`; clears `redir_valid`.
- `BranchTakenD` without advance: `redir_valid<=1`, `redir_target<=target`. With same-cycle advance, target is used via bypass and not latched.
- Delay slot: branch is in D while its slot is at `PCF`; the slot completes normally, the next fetch is the target. No squash.
- FSM, reset state S_REQ:
  - S_REQ: `inst_req=1` if `PCF[1:0]==0`. `inst_addr_ok` → S_DATA. Misaligned: no request, `AdELF=1`, `InstrF=0`, go S_HOLD.
  - S_DATA: `inst_data_ok && !discard` → `InstValidF=1`, `InstrF=inst_rdata` combinationally. Advance → S_REQ; stall → latch data, go S_HOLD. `inst_data_ok && discard` → clear `discard`, S_REQ, no valid.
  - S_HOLD: `InstValidF=1`, held `InstrF`/`AdELF`; `!StallF` → advance, S_REQ.
- `ExcRedirect` (any state): `PCF<=ExcPC`, `redir_valid<=0`, `InstValidF` forced 0 that cycle, no advance. S_REQ with same-cycle `inst_addr_ok` → S_DATA with `discard=1`; S_REQ otherwise stays. S_DATA without `inst_data_ok` sets `discard=1`; with it, goes S_REQ. S_HOLD → S_REQ.

## Timing
- Reset: `PCF=RESET_PC`, S_REQ, `redir_valid=0`, `discard=0`, held `InstrF=0`, `AdELF=0`. `inst_req=1` first cycle after reset.
- Minimum per instruction: 2 cycles (addr_ok in S_REQ, data_ok in S_DATA). Data may return same cycle as next addr phase only after state returns to S_REQ. At most one request outstanding.
- Redirect latency: first request after the delay-slot advance carries the target; `ExcPC` presented on `inst_addr` the cycle after `ExcRedirect` (or after discard clears).
- `inst_addr` stable while `inst_req && !inst_addr_ok` unless `ExcRedirect`.
- No outputs depend on `StallF` except advance; `inst_req` is independent of `inst_addr_ok`.

## Test plan
- Reset, bridge answers addr_ok then data_ok each 1 cycle → `inst_addr` 0xBFC00000, 0xBFC00004, 0xBFC00008; one instruction per 2 cycles.
- BEQ in D at 0xBFC00010 (`PCPlus4D`=0xBFC00014, `ImmD`=0x0004) taken, slot fetching at 0xBFC00014 → next `inst_addr` 0xBFC00024, slot delivered once.
- `BranchTakenD` with `StallF=1` held 3 cycles and 2-cycle data_ok delay → target latched, used exactly once after stall release; following fetch is target+4.
- `PCSrcD`=10, `RegTargetD`=0x80000002 → no `inst_req`, `InstValidF=1`, `AdELF=1`, `InstrF=0`.
- `ExcRedirect` (`ExcPC`=0xBFC00380) in S_DATA, data_ok arrives 2 cycles later → that data dropped, `InstValidF` stays 0, next `inst_addr` 0xBFC00380.
- `reset` asserted in S_DATA → next cycle `PCF`=0xBFC00000, `inst_req=1`, `InstValidF=0`.

Source files
------------

// File: rtl/pc_fetch_if.sv
// Instruction-side SRAM-like channel between the fetch controller (master)
// and the instruction AXI bridge (slave).
interface pc_fetch_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Fetch PC holder and instruction-port sequencer with MIPS delay-slot redirects
// (branch/jump/register-jump from decode, exception/ERET from the pipeline).
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        StallF,
  input  logic        BranchTakenD,
  input  logic [1:0]  PCSrcD,
  input  logic [31:0] PCPlus4D,
  input  logic [15:0] ImmD,
  input  logic [25:0] InstrIndexD,
  input  logic [31:0] RegTargetD,
  input  logic        ExcRedirect,
  input  logic [31:0] ExcPC,
  pc_fetch_if.master  ibus,
  output logic [31:0] PCF,
  output logic [31:0] InstrF,
  output logic        InstValidF,
  output logic        AdELF
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_DATA = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redir_target_q, redir_target_d;
  logic        redir_valid_q, redir_valid_d;
  logic        discard_q, discard_d;
  logic [31:0] held_instr_q, held_instr_d;
  logic        held_adel_q, held_adel_d;

  logic [31:0] branch_target_s;
  logic [31:0] next_pc_s;
  logic        aligned_s;
  logic        valid_s;
  logic        advance_s;

  // Control-transfer target selected by the decode-stage PC source
  always_comb begin
    case (PCSrcD)
      2'b01:   branch_target_s = {PCPlus4D[31:28], InstrIndexD, 2'b00};
      2'b10:   branch_target_s = RegTargetD;
      default: branch_target_s = PCPlus4D + {{14{ImmD[15]}}, ImmD, 2'b00};
    endcase
  end

  // A live taken branch bypasses the redirect latch so a same-cycle advance
  // still lands on the target after the delay slot.
  always_comb begin
    if (BranchTakenD) begin
      next_pc_s = branch_target_s;
    end else if (redir_valid_q) begin
      next_pc_s = redir_target_q;
    end else begin
      next_pc_s = pc_q + 32'd4;
    end
  end

  assign aligned_s     = (pc_q[1:0] == 2'b00);
  assign ibus.inst_req  = (state_q == S_REQ) && aligned_s;
  assign ibus.inst_addr = pc_q;
  assign PCF            = pc_q;
  assign InstValidF     = valid_s;
  assign advance_s      = valid_s && !StallF;

  // F-stage output slot: live bridge data, held data, or misaligned fault
  always_comb begin
    valid_s = 1'b0;
    InstrF  = 32'd0;
    AdELF   = 1'b0;
    case (state_q)
      S_REQ: begin
        AdELF = !aligned_s;
      end
      S_DATA: begin
        if (ibus.inst_data_ok && !discard_q && !ExcRedirect) begin
          valid_s = 1'b1;
          InstrF  = ibus.inst_rdata;
        end else begin
          valid_s = 1'b0;
        end
      end
      S_HOLD: begin
        valid_s = !ExcRedirect;
        InstrF  = held_instr_q;
        AdELF   = held_adel_q;
      end
      default: begin
        valid_s = 1'b0;
      end
    endcase
  end

  // Next-state: PC/redirect bookkeeping and fetch sequencing
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    redir_target_d = redir_target_q;
    redir_valid_d  = redir_valid_q;
    discard_d      = discard_q;
    held_instr_d   = held_instr_q;
    held_adel_d    = held_adel_q;

    if (ExcRedirect) begin
      pc_d          = ExcPC;
      redir_valid_d = 1'b0;
    end else if (advance_s) begin
      pc_d          = next_pc_s;
      redir_valid_d = 1'b0;
    end else if (BranchTakenD) begin
      redir_valid_d  = 1'b1;
      redir_target_d = branch_target_s;
    end else begin
      redir_valid_d = redir_valid_q;
    end

    case (state_q)
      S_REQ: begin
        if (!aligned_s) begin
          if (!ExcRedirect) begin
            state_d      = S_HOLD;
            held_instr_d = 32'd0;
            held_adel_d  = 1'b1;
          end else begin
            state_d = S_REQ;
          end
        end else if (ibus.inst_addr_ok) begin
          // A request accepted alongside a redirect is for the old PC
          state_d   = S_DATA;
          discard_d = ExcRedirect;
        end else begin
          state_d = S_REQ;
        end
      end
      S_DATA: begin
        if (ibus.inst_data_ok) begin
          if (ExcRedirect || discard_q) begin
            state_d   = S_REQ;
            discard_d = 1'b0;
          end else if (advance_s) begin
            state_d = S_REQ;
          end else begin
            state_d      = S_HOLD;
            held_instr_d = ibus.inst_rdata;
            held_adel_d  = 1'b0;
          end
        end else if (ExcRedirect) begin
          discard_d = 1'b1;
        end else begin
          state_d = S_DATA;
        end
      end
      S_HOLD: begin
        if (ExcRedirect || advance_s) begin
          state_d = S_REQ;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_REQ;
      pc_q           <= RESET_PC;
      redir_target_q <= 32'd0;
      redir_valid_q  <= 1'b0;
      discard_q      <= 1'b0;
      held_instr_q   <= 32'd0;
      held_adel_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      redir_target_q <= redir_target_d;
      redir_valid_q  <= redir_valid_d;
      discard_q      <= discard_d;
      held_instr_q   <= held_instr_d;
      held_adel_q    <= held_adel_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: bridge model, program-order fetch
// model, directed scenarios and randomized traffic.
module tb_pc_fetch_ctrl;
  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, StallF, BranchTakenD, ExcRedirect;
  logic [1:0]  PCSrcD;
  logic [31:0] PCPlus4D, RegTargetD, ExcPC;
  logic [15:0] ImmD;
  logic [25:0] InstrIndexD;
  logic [31:0] PCF, InstrF;
  logic        InstValidF, AdELF;

  pc_fetch_if bus();

  pc_fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clock(clock), .reset(reset), .StallF(StallF), .BranchTakenD(BranchTakenD),
    .PCSrcD(PCSrcD), .PCPlus4D(PCPlus4D), .ImmD(ImmD), .InstrIndexD(InstrIndexD),
    .RegTargetD(RegTargetD), .ExcRedirect(ExcRedirect), .ExcPC(ExcPC),
    .ibus(bus), .PCF(PCF), .InstrF(InstrF), .InstValidF(InstValidF), .AdELF(AdELF)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Per-cycle stimulus chosen by the scenario code
  bit          d_rst, d_stall, d_br, d_exc;
  logic [1:0]  d_src;
  logic [31:0] d_p4, d_reg, d_excpc;
  logic [15:0] d_imm;
  logic [25:0] d_idx;

  // Reference model: PC of the instruction to be delivered next, pending redirect
  logic [31:0] m_pc, m_pend_tgt;
  bit          m_pend, br_armed;
  int          idle;

  // Bridge model
  bit          b_busy, rand_lat;
  logic [31:0] b_addr;
  int          b_cnt, b_wait, addr_lat, data_lat;
  bit          prev_wait, obs_valid;
  logic [31:0] prev_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic logic [31:0] ctl_target(input logic [1:0] src, input logic [31:0] p4,
                                             input logic [15:0] imm, input logic [25:0] idx,
                                             input logic [31:0] rt);
    int off;
    off = int'($signed(imm)) * 4;
    case (src)
      2'b01:   return {p4[31:28], idx, 2'b00};
      2'b10:   return rt;
      default: return p4 + 32'(off);
    endcase
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
  endtask

  // One clock cycle: bridge responds, inputs applied, outputs checked, models stepped
  task automatic tick();
    bit          adv;
    logic [31:0] tgt;
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b0;
    bus.inst_rdata   = $urandom;
    if (b_busy) begin
      check1("single_outstanding", bus.inst_req, 1'b0);
      if (b_cnt == 0) begin
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = mem_word(b_addr);
      end
    end else if (bus.inst_req === 1'b1 && b_wait >= addr_lat) begin
      bus.inst_addr_ok = 1'b1;
    end
    reset = d_rst; StallF = d_stall; BranchTakenD = d_br; PCSrcD = d_src;
    PCPlus4D = d_p4; ImmD = d_imm; InstrIndexD = d_idx; RegTargetD = d_reg;
    ExcRedirect = d_exc; ExcPC = d_excpc;
    #1;
    obs_valid = InstValidF;
    if (d_rst) begin
      m_pc = RESET_PC; m_pend = 1'b0; br_armed = 1'b1; idle = 0;
    end else begin
      check32("pcf", PCF, m_pc);
      check32("inst_addr", bus.inst_addr, m_pc);
      if (m_pc[1:0] != 2'b00) check1("no_req_misaligned", bus.inst_req, 1'b0);
      if (prev_wait && bus.inst_req) check32("addr_stable", bus.inst_addr, prev_addr);
      if (d_exc) check1("valid_on_exc", InstValidF, 1'b0);
      adv = InstValidF && !d_stall;
      if (adv) begin
        check1("adel", AdELF, m_pc[1:0] != 2'b00);
        check32("instr", InstrF, (m_pc[1:0] != 2'b00) ? 32'd0 : mem_word(m_pc));
      end
      tgt = ctl_target(d_src, d_p4, d_imm, d_idx, d_reg);
      if (d_exc) begin
        m_pc = d_excpc; m_pend = 1'b0; br_armed = 1'b1;
      end else if (adv) begin
        m_pc = d_br ? tgt : (m_pend ? m_pend_tgt : m_pc + 32'd4);
        m_pend = 1'b0; br_armed = 1'b1;
      end else if (d_br) begin
        m_pend = 1'b1; m_pend_tgt = tgt;
      end
      if (d_br) br_armed = 1'b0;
      if (adv || d_exc) idle = 0;
      else idle++;
      if (idle > 60) begin
        check1("liveness", 1'b0, 1'b1);
        idle = 0;
      end
    end
    prev_wait = (bus.inst_req === 1'b1) && !bus.inst_addr_ok && !d_exc && !d_rst;
    prev_addr = bus.inst_addr;
    if (d_rst) begin
      b_busy = 1'b0; b_wait = 0;
    end else if (b_busy) begin
      if (b_cnt == 0) b_busy = 1'b0;
      else b_cnt--;
    end else if (bus.inst_addr_ok) begin
      b_busy = 1'b1; b_addr = bus.inst_addr; b_cnt = data_lat - 1; b_wait = 0;
      if (rand_lat) begin
        addr_lat = $urandom_range(0, 2);
        data_lat = $urandom_range(1, 3);
      end
    end else if (bus.inst_req === 1'b1) b_wait++;
    else b_wait = 0;
    @(posedge clock);
    #1;
  endtask

  initial begin
    d_rst = 1'b1; d_stall = 1'b0; d_br = 1'b0; d_exc = 1'b0; d_src = 2'b00;
    d_p4 = 32'd0; d_reg = 32'd0; d_excpc = 32'd0; d_imm = 16'd0; d_idx = 26'd0;
    b_busy = 1'b0; b_cnt = 0; b_wait = 0; addr_lat = 0; data_lat = 1; rand_lat = 1'b0;
    prev_wait = 1'b0; prev_addr = 32'd0; m_pc = RESET_PC; m_pend = 1'b0; br_armed = 1'b1;
    bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0; bus.inst_rdata = 32'd0;

    tick(); tick();
    d_rst = 1'b0;
    check32("reset_pcf", PCF, 32'hBFC0_0000);
    check1("reset_req", bus.inst_req, 1'b1);
    check1("reset_valid", InstValidF, 1'b0);

    // Sequential fetch, one instruction per two cycles
    tick(); tick();
    check1("seq_delivered", obs_valid, 1'b1);
    check32("seq_addr1", bus.inst_addr, 32'hBFC0_0004);
    tick(); tick();
    check32("seq_addr2", bus.inst_addr, 32'hBFC0_0008);
    repeat (6) tick();
    check32("slot_pc", PCF, 32'hBFC0_0014);

    // BEQ resolved while its slot completes: bypassed target
    tick();
    d_br = 1'b1; d_src = 2'b00; d_p4 = 32'hBFC0_0014; d_imm = 16'h0004;
    tick();
    d_br = 1'b0;
    check1("beq_slot_valid", obs_valid, 1'b1);
    check32("beq_target", bus.inst_addr, 32'hBFC0_0024);

    // Jump during a stalled, slow fetch: latched target used once
    data_lat = 2;
    d_stall = 1'b1; d_br = 1'b1; d_src = 2'b01; d_p4 = 32'hBFC0_0028; d_idx = 26'h000_0100;
    tick();
    d_br = 1'b0;
    tick(); tick();
    check1("stall_data_valid", obs_valid, 1'b1);
    d_stall = 1'b0;
    tick();
    check32("jump_target", PCF, 32'hB000_0400);
    data_lat = 1;
    tick(); tick();
    check32("jump_target_plus4", PCF, 32'hB000_0404);

    // Register jump to a misaligned address
    d_br = 1'b1; d_src = 2'b10; d_reg = 32'h8000_0002;
    tick();
    d_br = 1'b0;
    tick();
    check32("misaligned_pc", PCF, 32'h8000_0002);
    check1("misaligned_no_req", bus.inst_req, 1'b0);
    d_stall = 1'b1;
    tick();
    check1("adel_valid", InstValidF, 1'b1);
    check1("adel_flag", AdELF, 1'b1);
    check32("adel_instr", InstrF, 32'd0);
    d_stall = 1'b0;
    tick();

    // Exception redirect while a request is in flight
    d_exc = 1'b1; d_excpc = 32'hBFC0_0100;
    tick();
    d_exc = 1'b0; data_lat = 3;
    tick();
    d_exc = 1'b1; d_excpc = 32'hBFC0_0380;
    tick();
    check1("exc_valid_low", obs_valid, 1'b0);
    d_exc = 1'b0;
    tick(); tick();
    check1("exc_drop_valid", obs_valid, 1'b0);
    check32("exc_addr", bus.inst_addr, 32'hBFC0_0380);
    check1("exc_req", bus.inst_req, 1'b1);

    // Reset while waiting for data
    data_lat = 2;
    tick();
    d_rst = 1'b1;
    tick();
    d_rst = 1'b0;
    check32("rst_sdata_pcf", PCF, 32'hBFC0_0000);
    check1("rst_sdata_req", bus.inst_req, 1'b1);
    check1("rst_sdata_valid", InstValidF, 1'b0);

    // Randomized traffic against the model
    rand_lat = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      d_stall = ($urandom_range(0, 3) == 0);
      d_exc   = (m_pc[1:0] != 2'b00) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 49) == 0);
      d_excpc = $urandom & 32'hFFFF_FFFC;
      d_br    = br_armed && ($urandom_range(0, 6) == 0);
      d_src   = 2'($urandom);
      d_p4    = m_pc;
      d_imm   = 16'($urandom);
      d_idx   = 26'($urandom);
      d_reg   = $urandom & (($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      d_rst   = ($urandom_range(0, 999) == 0);
      tick();
    end
    d_rst = 1'b0; d_br = 1'b0; d_exc = 1'b0; d_stall = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
